// File: rtl/gpio_sequencer_pkg.sv
// Shared constants for the GPIO sequencer: FSM states, CTRL/status bit
// positions and the table/ctrl address-select offset.
package gpio_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WACK,
    ST_DELAY
  } state_t;

  localparam int unsigned CTRL_START = 31;
  localparam int unsigned CTRL_ABORT = 30;
  localparam int unsigned CTRL_LOOP  = 29;
  localparam int unsigned CTRL_DONE  = 28;
  localparam int unsigned STAT_BUSY  = 31;
  localparam int unsigned INDEX_LSB  = 16;

  // Table select is wb_addr[LGTBL + ADDR_SEL_OFS]; below it sit idx and word.
  localparam int unsigned ADDR_SEL_OFS = 1;

endpackage

// File: rtl/gpio_sequencer_if.sv
// Bus bundle for the sequencer: CPU-facing WB slave side and GPIO-facing
// WB master side.
interface gpio_sequencer_if #(
  parameter int unsigned LGTBL = 4
) ();

  logic             wb_cyc;
  logic             wb_stb;
  logic             wb_we;
  logic [LGTBL+1:0] wb_addr;
  logic [31:0]      wb_wdata;
  logic             wb_ack;
  logic             wb_stall;
  logic [31:0]      wb_rdata;

  logic             gp_cyc;
  logic             gp_stb;
  logic             gp_we;
  logic [31:0]      gp_data;
  logic             gp_ack;
  logic             gp_stall;

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata,
    output wb_ack, wb_stall, wb_rdata
  );

  modport master (
    output gp_cyc, gp_stb, gp_we, gp_data,
    input  gp_ack, gp_stall
  );

endinterface

// File: rtl/gpio_sequencer.sv
// Plays a CPU-loaded table of {mask,value} writes with per-entry delays onto
// a set/mask GPIO port over a Wishbone master interface.
module gpio_sequencer #(
  parameter int unsigned LGTBL = 4,
  parameter int unsigned DLYW  = 24
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  gpio_sequencer_if.slave       bus,
  gpio_sequencer_if.master      gp,
  output logic                  o_int
);

  import gpio_seq_pkg::*;

  localparam int unsigned DEPTH = 1 << LGTBL;

  logic [31:0]      tbl_pat [DEPTH];
  logic [DLYW-1:0]  tbl_dly [DEPTH];

  state_t           state;
  logic             busy;
  logic             done;
  logic             loop_en;
  logic             abort_pend;
  logic [LGTBL-1:0] index;
  logic [LGTBL-1:0] last;
  logic [DLYW-1:0]  cnt;
  logic             cyc_r;
  logic             stb_r;
  logic [31:0]      data_r;
  logic             ack_r;
  logic [31:0]      rdata_r;
  logic [31:0]      status;

  logic             bus_req;
  logic             bus_wr;
  logic             tbl_sel;
  logic [LGTBL-1:0] wr_idx;
  logic             ctrl_wr;
  logic             start_req;
  logic             abort_req;
  logic             abort_now;

  assign bus_req   = bus.wb_cyc & bus.wb_stb;
  assign bus_wr    = bus_req & bus.wb_we;
  assign tbl_sel   = bus.wb_addr[LGTBL+ADDR_SEL_OFS];
  assign wr_idx    = bus.wb_addr[LGTBL:1];
  assign ctrl_wr   = bus_wr & ~tbl_sel;
  assign abort_req = ctrl_wr & bus.wb_wdata[CTRL_ABORT];
  assign start_req = ctrl_wr & bus.wb_wdata[CTRL_START] & ~bus.wb_wdata[CTRL_ABORT];
  assign abort_now = abort_req | abort_pend;

  assign bus.wb_ack   = ack_r;
  assign bus.wb_stall = 1'b0;
  assign bus.wb_rdata = rdata_r;
  assign gp.gp_cyc    = cyc_r;
  assign gp.gp_stb    = stb_r;
  assign gp.gp_we     = cyc_r;
  assign gp.gp_data   = data_r;

  // Table RAMs are not reset; writes while running only affect unfetched entries.
  always_ff @(posedge i_clk) begin
    if (bus_wr && tbl_sel) begin
      if (bus.wb_addr[0])
        tbl_dly[wr_idx] <= bus.wb_wdata[DLYW-1:0];
      else
        tbl_pat[wr_idx] <= bus.wb_wdata;
    end
  end

  always_comb begin
    status                       = '0;
    status[STAT_BUSY]            = busy;
    status[CTRL_LOOP]            = loop_en;
    status[CTRL_DONE]            = done;
    status[INDEX_LSB +: LGTBL]   = index;
    status[LGTBL-1:0]            = last;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ack_r   <= 1'b0;
      rdata_r <= '0;
    end else begin
      ack_r <= bus_req;
      if (bus_req)
        rdata_r <= status;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      loop_en    <= 1'b0;
      abort_pend <= 1'b0;
      index      <= '0;
      last       <= '0;
      cnt        <= '0;
      cyc_r      <= 1'b0;
      stb_r      <= 1'b0;
      data_r     <= '0;
      o_int      <= 1'b0;
    end else begin
      o_int <= 1'b0;
      case (state)
        ST_IDLE: begin
          abort_pend <= 1'b0;
          if (start_req) begin
            index   <= '0;
            done    <= 1'b0;
            busy    <= 1'b1;
            loop_en <= bus.wb_wdata[CTRL_LOOP];
            last    <= bus.wb_wdata[LGTBL-1:0];
            state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (abort_now) begin
            busy       <= 1'b0;
            abort_pend <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            data_r <= tbl_pat[index];
            cnt    <= tbl_dly[index];
            cyc_r  <= 1'b1;
            stb_r  <= 1'b1;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WACK: begin
          // An abort here is held until the bus transaction has completed.
          if (abort_req)
            abort_pend <= 1'b1;
          if (state == ST_WACK || !gp.gp_stall) begin
            stb_r <= 1'b0;
            if (gp.gp_ack) begin
              cyc_r <= 1'b0;
              if (abort_now) begin
                busy       <= 1'b0;
                abort_pend <= 1'b0;
                state      <= ST_IDLE;
              end else begin
                state <= ST_DELAY;
              end
            end else begin
              state <= ST_WACK;
            end
          end
        end
        ST_DELAY: begin
          if (abort_now) begin
            busy       <= 1'b0;
            abort_pend <= 1'b0;
            state      <= ST_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (index == last) begin
            if (loop_en) begin
              index <= '0;
              state <= ST_FETCH;
            end else begin
              done  <= 1'b1;
              o_int <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            index <= index + 1'b1;
            state <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_sequencer.sv
// Scoreboard bench for gpio_sequencer: directed runs push expected GPIO writes
// and status words; a negedge monitor/GPIO responder pops and compares them.
module tb_gpio_sequencer;

  localparam int unsigned LGTBL = 4;
  localparam int unsigned DLYW  = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic irq;

  gpio_sequencer_if #(.LGTBL(LGTBL)) bus ();

  gpio_sequencer #(.LGTBL(LGTBL), .DLYW(DLYW)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave),
    .gp        (bus.master),
    .o_int     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
  } wb_exp_t;

  int          checks = 0;
  int          errors = 0;
  wb_exp_t     wb_q[$];
  logic [31:0] gp_q[$];
  int          acc_t[$];
  int          cyc_n = 0;
  int          int_cnt = 0;
  int          stall_left = 0;
  int          ack_delay = 0;
  int          ack_wait = 0;
  bit          acc_pend = 1'b0;
  int          stall_seen = 0;
  int          wack_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // Monitor plus GPIO-port responder with programmable stall and ack latency.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_pend    = 1'b0;
        bus.gp_ack  = 1'b0;
        bus.gp_stall = 1'b0;
      end else begin
        if (irq) int_cnt++;
        if (bus.wb_ack) begin
          check("wb_ack_expected", 32'(wb_q.size() != 0), 32'd1);
          if (wb_q.size() != 0) begin
            e = wb_q.pop_front();
            if (e.is_rd) check("status_read", bus.wb_rdata, e.data);
          end
        end
        bus.gp_ack = 1'b0;
        if (acc_pend) begin
          check("gp_cyc_held", 32'(bus.gp_cyc), 32'd1);
          check("gp_stb_dropped", 32'(bus.gp_stb), 32'd0);
          wack_seen++;
          if (ack_wait == 0) begin
            bus.gp_ack = 1'b1;
            acc_pend   = 1'b0;
          end else begin
            ack_wait--;
          end
        end else if (bus.gp_stb) begin
          check("gp_write_expected", 32'(gp_q.size() != 0), 32'd1);
          if (stall_left > 0) begin
            bus.gp_stall = 1'b1;
            stall_left--;
            stall_seen++;
            if (gp_q.size() != 0) check("gp_data_stalled", bus.gp_data, gp_q[0]);
          end else begin
            bus.gp_stall = 1'b0;
            acc_t.push_back(cyc_n);
            if (gp_q.size() != 0) check("gp_data", bus.gp_data, gp_q.pop_front());
            check("gp_we", 32'(bus.gp_we), 32'd1);
            acc_pend = 1'b1;
            ack_wait = ack_delay;
          end
        end else begin
          bus.gp_stall = 1'b0;
        end
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [LGTBL+1:0] a,
                         input logic [31:0] d, input logic [31:0] exp);
    wb_exp_t e;
    @(posedge clk);
    #1;
    bus.wb_cyc   = 1'b1;
    bus.wb_stb   = 1'b1;
    bus.wb_we    = we;
    bus.wb_addr  = a;
    bus.wb_wdata = d;
    e.is_rd = ~we;
    e.data  = exp;
    wb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
    bus.wb_we  = 1'b0;
  endtask

  task automatic wr_ctrl(input logic [31:0] d);
    wb_xfer(1'b1, '0, d, '0);
  endtask

  task automatic rd_status(input logic [31:0] exp);
    wb_xfer(1'b0, '0, '0, exp);
  endtask

  task automatic tbl_write(input logic [LGTBL-1:0] idx, input logic [31:0] pat,
                           input logic [31:0] dly);
    wb_xfer(1'b1, {1'b1, idx, 1'b0}, pat, '0);
    wb_xfer(1'b1, {1'b1, idx, 1'b1}, dly, '0);
  endtask

  task automatic wait_int(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (int_cnt >= target) break;
      @(posedge clk);
    end
    check("int_count", 32'(int_cnt), 32'(target));
  endtask

  task automatic wait_acc(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (acc_t.size() >= n) break;
      @(posedge clk);
    end
    check("gp_write_reached", 32'(acc_t.size() >= n), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int base;
    int ic;
    bus.wb_cyc   = 1'b0;
    bus.wb_stb   = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_wdata = '0;
    bus.gp_ack   = 1'b0;
    bus.gp_stall = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_gp_cyc", 32'(bus.gp_cyc), 32'd0);
    check("rst_gp_stb", 32'(bus.gp_stb), 32'd0);
    check("rst_gp_we", 32'(bus.gp_we), 32'd0);
    check("rst_int", 32'(irq), 32'd0);
    check("rst_wb_ack", 32'(bus.wb_ack), 32'd0);
    check("rst_wb_stall", 32'(bus.wb_stall), 32'd0);
    check("rst_wb_rdata", bus.wb_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd_status(32'h0000_0000);

    // 1: two-entry one-shot run
    tbl_write(4'd0, 32'h0001_0001, 32'd5);
    tbl_write(4'd1, 32'h0001_0000, 32'd0);
    gp_q.push_back(32'h0001_0001);
    gp_q.push_back(32'h0001_0000);
    base = acc_t.size();
    ic   = int_cnt;
    wr_ctrl(32'h8000_0001);
    wait_int(ic + 1, 100);
    repeat (5) @(posedge clk);
    check("int_once", 32'(int_cnt), 32'(ic + 1));
    if (acc_t.size() >= base + 2)
      check("gap_delay5", 32'(acc_t[base+1] - acc_t[base]), 32'd9);
    rd_status(32'h1001_0001);

    // 2: looping run aborted after three writes
    gp_q.push_back(32'h0001_0001);
    gp_q.push_back(32'h0001_0000);
    gp_q.push_back(32'h0001_0001);
    base = acc_t.size();
    ic   = int_cnt;
    wr_ctrl(32'hA000_0001);
    wait_acc(base + 3, 100);
    wr_ctrl(32'h4000_0000);
    repeat (30) @(posedge clk);
    check("abort_no_int", 32'(int_cnt), 32'(ic));
    check("abort_write_count", 32'(acc_t.size() - base), 32'd3);
    if (acc_t.size() >= base + 3)
      check("gap_delay0", 32'(acc_t[base+2] - acc_t[base+1]), 32'd4);
    rd_status(32'h2000_0001);

    // 3: stall 7 clocks, ack 3 clocks late
    tbl_write(4'd0, 32'h0001_0001, 32'd2);
    gp_q.push_back(32'h0001_0001);
    stall_left = 7;
    ack_delay  = 3;
    stall_seen = 0;
    wack_seen  = 0;
    ic = int_cnt;
    wr_ctrl(32'h8000_0000);
    wait_int(ic + 1, 100);
    check("stall_cycles", 32'(stall_seen), 32'd7);
    check("wack_cycles", 32'(wack_seen), 32'd4);
    ack_delay = 0;
    rd_status(32'h1000_0000);

    // 4: start+abort in IDLE, then mid-run
    base = acc_t.size();
    wr_ctrl(32'hC000_0000);
    repeat (10) @(posedge clk);
    check("idle_abort_no_cycle", 32'(acc_t.size()), 32'(base));
    rd_status(32'h1000_0000);
    tbl_write(4'd0, 32'h0001_0001, 32'd5);
    gp_q.push_back(32'h0001_0001);
    ic = int_cnt;
    wr_ctrl(32'hA000_0001);
    wait_acc(base + 1, 100);
    wr_ctrl(32'hC000_0000);
    repeat (30) @(posedge clk);
    check("midrun_abort_writes", 32'(acc_t.size()), 32'(base + 1));
    check("midrun_abort_no_int", 32'(int_cnt), 32'(ic));
    rd_status(32'h2000_0001);

    // 5: rewrite idx1 while idx0 waits in DELAY
    tbl_write(4'd0, 32'h0001_0001, 32'd20);
    tbl_write(4'd1, 32'h00FF_0000, 32'd0);
    gp_q.push_back(32'h0001_0001);
    gp_q.push_back(32'h00FF_00AA);
    base = acc_t.size();
    ic   = int_cnt;
    wr_ctrl(32'h8000_0001);
    wait_acc(base + 1, 100);
    tbl_write(4'd1, 32'h00FF_00AA, 32'd0);
    wait_int(ic + 1, 100);
    check("rewrite_queue_drained", 32'(gp_q.size()), 32'd0);
    rd_status(32'h1001_0001);

    // 6: async reset while waiting for ack
    gp_q.push_back(32'h0001_0001);
    ack_delay = 6;
    base = acc_t.size();
    wr_ctrl(32'h8000_0000);
    wait_acc(base + 1, 100);
    #1;
    check("wack_cyc_before_reset", 32'(bus.gp_cyc), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_drops_cyc", 32'(bus.gp_cyc), 32'd0);
    check("reset_drops_stb", 32'(bus.gp_stb), 32'd0);
    check("reset_drops_we", 32'(bus.gp_we), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ack_delay = 0;
    rd_status(32'h0000_0000);
    repeat (5) @(posedge clk);

    check("wb_queue_empty", 32'(wb_q.size()), 32'd0);
    check("gp_queue_empty", 32'(gp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
